// File: rtl/moore_step_ctrl.sv
// moore_step_ctrl: button-driven step sequencer and output checker for 2-state Moore puzzle FSMs.
// Define MOORE_STEP_DEBOUNCE_EN to debounce step_btn for DEBOUNCE_CYCLES clocks.
module moore_step_ctrl #(
    parameter int MAX_STEPS       = 16,
    parameter int CNT_W           = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_btn,
    input  logic [1:0]           sw_in,
    input  logic [2:0]           start_state,
    input  logic [MAX_STEPS-1:0] target_seq,
    input  logic [CNT_W-1:0]     target_len,
    input  logic                 fsm_out,
    output logic                 fsm_reset,
    output logic                 fsm_ctrl,
    output logic [1:0]           fsm_sw,
    output logic [2:0]           fsm_state_in,
    output logic [CNT_W-1:0]     step_count,
    output logic                 busy,
    output logic                 win,
    output logic                 fail
);
    typedef enum logic [2:0] {IDLE, LOAD, ARMED, STEP, CHECK, WIN, FAIL} state_t;

    if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= MAX_STEPS) begin : g_param_err
        $error("moore_step_ctrl: invalid parameters");
    end

    state_t           state_q, state_d;
    logic             s1_q, s2_q, prev_q, evt_q, lvl;
    logic [1:0]       sw_q, sw_d;
    logic [2:0]       sin_q, sin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, eff_len;
    logic             rst_q, ctrl_q, busy_q, win_q, fail_q, tbit;

`ifdef MOORE_STEP_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic            db_q;
    logic [DB_W-1:0] db_cnt_q;
    // Any sample that disagrees with the held level must persist unbroken to flip it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else if (s2_q == db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_q     <= s2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end
    assign lvl = db_q;
`else
    assign lvl = s2_q;
`endif

    assign eff_len = (target_len > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : target_len;
    assign cnt_inc = cnt_q + 1'b1;
    assign tbit    = |(target_seq & (MAX_STEPS'(1) << cnt_q));

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        sin_d   = sin_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = LOAD;
            sin_d   = start_state;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD:    state_d = (eff_len == '0) ? WIN : ARMED;
                ARMED: begin
                    if (evt_q) begin
                        sw_d    = sw_in;
                        state_d = STEP;
                    end
                end
                STEP:    state_d = CHECK;
                CHECK: begin
                    if (fsm_out != tbit) begin
                        state_d = FAIL;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == eff_len) ? WIN : ARMED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            evt_q   <= 1'b0;
            sw_q    <= '0;
            sin_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
            ctrl_q  <= 1'b0;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= step_btn;
            s2_q    <= s1_q;
            prev_q  <= lvl;
            evt_q   <= lvl & ~prev_q & ~start;
            sw_q    <= sw_d;
            sin_q   <= sin_d;
            cnt_q   <= cnt_d;
            rst_q   <= state_d == LOAD;
            ctrl_q  <= state_d == STEP;
            busy_q  <= state_d == LOAD || state_d == STEP || state_d == CHECK;
            win_q   <= state_d == WIN;
            fail_q  <= state_d == FAIL;
        end
    end

    assign fsm_reset    = rst_q;
    assign fsm_ctrl     = ctrl_q;
    assign fsm_sw       = sw_q;
    assign fsm_state_in = sin_q;
    assign step_count   = cnt_q;
    assign busy         = busy_q;
    assign win          = win_q;
    assign fail         = fail_q;
endmodule

// File: tb/tb_moore_step_ctrl.sv
// tb_moore_step_ctrl: directed bench for moore_step_ctrl driving a small 2-state Moore FSM model.
module tb_moore_step_ctrl;
    localparam int MAX_STEPS = 16;
    localparam int CNT_W     = 5;
`ifdef MOORE_STEP_DEBOUNCE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic                 clk, reset, start, step_btn, fsm_out;
    logic                 fsm_reset, fsm_ctrl, busy, win, fail;
    logic [1:0]           sw_in, fsm_sw;
    logic [2:0]           start_state, fsm_state_in;
    logic [MAX_STEPS-1:0] target_seq;
    logic [CNT_W-1:0]     target_len, step_count;
    logic                 m_st;
    int                   n_chk = 0, n_pass = 0, ctrl_cnt = 0, overlap = 0;

    moore_step_ctrl #(.MAX_STEPS(MAX_STEPS), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .step_btn(step_btn), .sw_in(sw_in),
        .start_state(start_state), .target_seq(target_seq), .target_len(target_len),
        .fsm_out(fsm_out), .fsm_reset(fsm_reset), .fsm_ctrl(fsm_ctrl), .fsm_sw(fsm_sw),
        .fsm_state_in(fsm_state_in), .step_count(step_count), .busy(busy), .win(win), .fail(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Puzzle FSM: state0 with sw>0 -> state1, out 0; state1 with sw==1 -> state0, out 1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st    <= 1'b0;
            fsm_out <= 1'b0;
        end else if (fsm_reset) begin
            m_st    <= fsm_state_in[0];
            fsm_out <= 1'b0;
        end else if (fsm_ctrl) begin
            if (!m_st && fsm_sw != 2'd0) begin
                m_st    <= 1'b1;
                fsm_out <= 1'b0;
            end else if (m_st && fsm_sw == 2'd1) begin
                m_st    <= 1'b0;
                fsm_out <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (fsm_ctrl) ctrl_cnt <= ctrl_cnt + 1;
        if (fsm_ctrl && fsm_reset) overlap <= overlap + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_run(input logic [2:0] s);
        start_state = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    task automatic press();
        step_btn = 1'b1;
        tick(LAT + 4);
        step_btn = 1'b0;
        tick(LAT + 8);
    endtask

    task automatic wait_ctrl(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            ok = fsm_ctrl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; step_btn = 1'b0; sw_in = 2'd0;
        start_state = 3'd0; target_seq = '0; target_len = '0;
        #1 reset = 1'b0;
        #2;
        n_chk++;
        if ({fsm_reset, fsm_ctrl, fsm_sw, fsm_state_in, step_count, busy, win, fail} !== 15'd0)
            $display("FAIL reset_outputs got %b want 0", {fsm_reset, fsm_ctrl, fsm_sw, fsm_state_in, step_count, busy, win, fail});
        else n_pass++;
        tick(2);
        reset = 1'b1;
        tick(2);
        n_chk++;
        if ({busy, win, fail, fsm_reset} !== 4'd0) $display("FAIL idle_after_reset got %b want 0000", {busy, win, fail, fsm_reset});
        else n_pass++;
    endtask

    task automatic test_load();
        target_len = 5'd2;
        start_state = 3'd6;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++;
        if ({fsm_reset, busy, fsm_ctrl} !== 3'b110) $display("FAIL load_pulse got %b want 110", {fsm_reset, busy, fsm_ctrl});
        else n_pass++;
        n_chk++;
        if (fsm_state_in !== 3'd6) $display("FAIL load_state got %0d want 6", fsm_state_in);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({fsm_reset, busy, win} !== 3'b000) $display("FAIL load_width got %b want 000", {fsm_reset, busy, win});
        else n_pass++;
        load_run(3'd0);
        n_chk++;
        if (fsm_state_in !== 3'd0) $display("FAIL load_state0 got %0d want 0", fsm_state_in);
        else n_pass++;
    endtask

    task automatic test_win();
        int c;
        target_seq = 16'b10; target_len = 5'd2;
        load_run(3'd0);
        sw_in = 2'd1;
        c = ctrl_cnt;
        press();
        n_chk++;
        if (ctrl_cnt - c != 1 || step_count !== 5'd1 || win !== 1'b0)
            $display("FAIL win_step1 got ctrl=%0d cnt=%0d win=%b want 1 1 0", ctrl_cnt - c, step_count, win);
        else n_pass++;
        press();
        n_chk++;
        if (ctrl_cnt - c != 2) $display("FAIL win_ctrl got %0d want 2", ctrl_cnt - c);
        else n_pass++;
        n_chk++;
        if ({win, fail, busy, step_count} !== {3'b100, 5'd2})
            $display("FAIL win_final got win=%b fail=%b busy=%b cnt=%0d want 1 0 0 2", win, fail, busy, step_count);
        else n_pass++;
    endtask

    task automatic test_fail();
        int c;
        target_seq = 16'b1; target_len = 5'd2;
        load_run(3'd0);
        sw_in = 2'd2;
        press();
        n_chk++;
        if ({fail, win, step_count} !== {2'b10, 5'd0})
            $display("FAIL fail_final got fail=%b win=%b cnt=%0d want 1 0 0", fail, win, step_count);
        else n_pass++;
        c = ctrl_cnt;
        press();
        n_chk++;
        if (ctrl_cnt - c != 0 || fail !== 1'b1) $display("FAIL fail_terminal got ctrl=%0d fail=%b want 0 1", ctrl_cnt - c, fail);
        else n_pass++;
    endtask

    task automatic test_restart();
        logic ok;
        target_seq = 16'hAAAA; target_len = 5'd16; sw_in = 2'd1;
        start_state = 3'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++;
        if ({fail, fsm_reset} !== 2'b01) $display("FAIL restart_clear got fail=%b rst=%b want 0 1", fail, fsm_reset);
        else n_pass++;
        tick(1);
        press();
        sw_in = 2'd2;
        tick(3);
        sw_in = 2'd0;
        tick(3);
        n_chk++;
        if (fsm_sw !== 2'd1) $display("FAIL sw_hold got %0d want 1", fsm_sw);
        else n_pass++;
        sw_in = 2'd1;
        step_btn = 1'b1;
        wait_ctrl(ok);
        n_chk++;
        if (ok !== 1'b1) $display("FAIL restart_ctrl_seen got %b want 1", ok);
        else n_pass++;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++;
        if ({fsm_reset, busy, step_count} !== {2'b11, 5'd0})
            $display("FAIL restart_in_step got rst=%b busy=%b cnt=%0d want 1 1 0", fsm_reset, busy, step_count);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({busy, win, fail, step_count} !== 8'd0)
            $display("FAIL restart_no_check got busy=%b win=%b fail=%b cnt=%0d want 0 0 0 0", busy, win, fail, step_count);
        else n_pass++;
        step_btn = 1'b0;
        tick(LAT + 8);
        sw_in = 2'd3;
        press();
        n_chk++;
        if (fsm_sw !== 2'd3 || step_count !== 5'd1) $display("FAIL sw_latch got sw=%0d cnt=%0d want 3 1", fsm_sw, step_count);
        else n_pass++;
    endtask

    task automatic test_len0();
        target_len = 5'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_chk++;
        if ({fsm_reset, win} !== 2'b10) $display("FAIL len0_load got rst=%b win=%b want 1 0", fsm_reset, win);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({win, busy, step_count} !== {2'b10, 5'd0}) $display("FAIL len0_win got win=%b busy=%b cnt=%0d want 1 0 0", win, busy, step_count);
        else n_pass++;
    endtask

    task automatic test_len31();
        int c;
        target_seq = 16'hAAAA; target_len = 5'd31; sw_in = 2'd1;
        load_run(3'd0);
        repeat (15) press();
        n_chk++;
        if (step_count !== 5'd15 || win !== 1'b0) $display("FAIL clamp_15 got cnt=%0d win=%b want 15 0", step_count, win);
        else n_pass++;
        press();
        n_chk++;
        if ({win, busy, step_count} !== {2'b10, 5'd16}) $display("FAIL clamp_win got win=%b busy=%b cnt=%0d want 1 0 16", win, busy, step_count);
        else n_pass++;
        c = ctrl_cnt;
        press();
        n_chk++;
        if (ctrl_cnt - c != 0 || step_count !== 5'd16) $display("FAIL clamp_terminal got ctrl=%0d cnt=%0d want 0 16", ctrl_cnt - c, step_count);
        else n_pass++;
    endtask

    task automatic test_hold();
        int c;
        target_seq = 16'hAAAA; target_len = 5'd16; sw_in = 2'd1;
        load_run(3'd0);
        c = ctrl_cnt;
        step_btn = 1'b1;
        tick(40);
        step_btn = 1'b0;
        tick(LAT + 8);
        n_chk++;
        if (ctrl_cnt - c != 1 || step_count !== 5'd1) $display("FAIL hold_single got ctrl=%0d cnt=%0d want 1 1", ctrl_cnt - c, step_count);
        else n_pass++;
    endtask

    task automatic test_latency();
        step_btn = 1'b1;
        tick(LAT - 1);
        n_chk++;
        if (fsm_ctrl !== 1'b0) $display("FAIL latency_early got %b want 0", fsm_ctrl);
        else n_pass++;
        tick(1);
        n_chk++;
        if (fsm_ctrl !== 1'b1) $display("FAIL latency_step got %b want 1", fsm_ctrl);
        else n_pass++;
        step_btn = 1'b0;
        tick(LAT + 8);
        n_chk++;
        if (step_count !== 5'd2) $display("FAIL latency_count got %0d want 2", step_count);
        else n_pass++;
    endtask

`ifdef MOORE_STEP_DEBOUNCE_EN
    task automatic test_debounce();
        int c;
        c = ctrl_cnt;
        step_btn = 1'b1;
        tick(2);
        step_btn = 1'b0;
        tick(20);
        n_chk++;
        if (ctrl_cnt - c != 0) $display("FAIL debounce_glitch got %0d want 0", ctrl_cnt - c);
        else n_pass++;
        step_btn = 1'b1;
        tick(6);
        step_btn = 1'b0;
        tick(20);
        n_chk++;
        if (ctrl_cnt - c != 1 || step_count !== 5'd3) $display("FAIL debounce_press got ctrl=%0d cnt=%0d want 1 3", ctrl_cnt - c, step_count);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        logic ok;
        step_btn = 1'b1;
        wait_ctrl(ok);
        n_chk++;
        if (ok !== 1'b1) $display("FAIL areset_ctrl_seen got %b want 1", ok);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({fsm_reset, fsm_ctrl, fsm_sw, fsm_state_in, step_count, busy, win, fail} !== 15'd0)
            $display("FAIL areset_outputs got %b want 0", {fsm_reset, fsm_ctrl, fsm_sw, fsm_state_in, step_count, busy, win, fail});
        else n_pass++;
        step_btn = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        n_chk++;
        if ({busy, win, fail} !== 3'd0) $display("FAIL areset_idle got %b want 000", {busy, win, fail});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_win();
        test_fail();
        test_restart();
        test_len0();
        test_len31();
        test_hold();
        test_latency();
`ifdef MOORE_STEP_DEBOUNCE_EN
        test_debounce();
`endif
        test_async_reset();
        n_chk++;
        if (overlap != 0) $display("FAIL ctrl_reset_overlap got %0d want 0", overlap);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
